// File: rtl/ptp_bridge_pipe_arb.sv
// ptp_bridge_pipe_arb
//   Round-robin arbiter feeding a shared fixed-latency pipeline. Results are
//   routed back to the requester that issued them. Supports quiesce/drain.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/data    : per-requester request; requester i at req_data[i*W +: W]
//   req_ready         : one-hot-or-zero combinational grant
//   pipe_in_valid/data: registered issue into the shared pipeline
//   pipe_out_valid/data: pipeline result, DLY cycles after issue
//   rsp_valid/data    : one-hot result strobe to owner, shared payload
//   quiesce           : level, stop granting and drain
//   quiesce_done      : quiesced with nothing in flight
//   err_sticky        : pipeline result strobe disagreed with tracked issue
//
// Optional: define PTP_BRIDGE_PIPE_ARB_STATS_EN to add stat_sel/stat_cnt,
// a saturating 16-bit grant counter per requester.
module ptp_bridge_pipe_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int DLY  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                pipe_in_valid,
  output logic [W-1:0]        pipe_in_data,
  input  logic                pipe_out_valid,
  input  logic [W-1:0]        pipe_out_data,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W-1:0]        rsp_data,
  input  logic                quiesce,
  output logic                quiesce_done,
  output logic                err_sticky
`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  output logic [15:0]             stat_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(DLY + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIET} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            iss_valid_q, iss_valid_d;
  logic [W-1:0]    iss_data_q, iss_data_d;
  logic [IW-1:0]   iss_idx_q, iss_idx_d;
  logic [DLY-1:0]  trk_v_q, trk_v_d;
  logic [IW-1:0]   trk_idx_q [DLY];
  logic [IW-1:0]   trk_idx_d [DLY];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            err_sticky_q, err_sticky_d;
  logic [BW-1:0]   blank_q, blank_d;

  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] gnt_vec;
  logic            hs;
  logic            trk_hit;
  logic            mismatch;

  // Search starts one past the last winner; rst_n gates the grant so
  // req_ready drops the moment reset is asserted.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vec = '0;
    if (rst_n && (state_q == ST_RUN) && !quiesce && gnt_any) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    hs          = |gnt_vec;
    rr_ptr_d    = hs ? gnt_idx : rr_ptr_q;
    iss_valid_d = hs;
    iss_data_d  = hs ? req_data[32'(gnt_idx)*W +: W] : iss_data_q;
    iss_idx_d   = hs ? gnt_idx : iss_idx_q;

    trk_v_d[0]   = iss_valid_q;
    trk_idx_d[0] = iss_idx_q;
    for (int unsigned k = 1; k < DLY; k++) begin
      trk_v_d[k]   = trk_v_q[k-1];
      trk_idx_d[k] = trk_idx_q[k-1];
    end

    trk_hit     = pipe_out_valid && trk_v_q[DLY-1];
    rsp_valid_d = '0;
    if (trk_hit) begin
      rsp_valid_d[trk_idx_q[DLY-1]] = 1'b1;
    end
    rsp_data_d = trk_hit ? pipe_out_data : rsp_data_q;

    // For DLY cycles after reset the pipeline may still emit results issued
    // before reset; they are dropped without flagging an error.
    mismatch     = (pipe_out_valid != trk_v_q[DLY-1]);
    err_sticky_d = err_sticky_q | (mismatch && (blank_q == '0));
    blank_d      = (blank_q != '0) ? blank_q - BW'(1) : blank_q;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (quiesce) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!quiesce)                                 state_d = ST_RUN;
        else if ((trk_v_q == '0) && !iss_valid_q)     state_d = ST_QUIET;
      end
      ST_QUIET: if (!quiesce) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= IW'(NREQ - 1);
      iss_valid_q  <= 1'b0;
      iss_data_q   <= '0;
      iss_idx_q    <= '0;
      trk_v_q      <= '0;
      for (int unsigned k = 0; k < DLY; k++) trk_idx_q[k] <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_sticky_q <= 1'b0;
      blank_q      <= BW'(DLY);
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      iss_valid_q  <= iss_valid_d;
      iss_data_q   <= iss_data_d;
      iss_idx_q    <= iss_idx_d;
      trk_v_q      <= trk_v_d;
      for (int unsigned k = 0; k < DLY; k++) trk_idx_q[k] <= trk_idx_d[k];
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_sticky_q <= err_sticky_d;
      blank_q      <= blank_d;
    end
  end

  assign req_ready     = gnt_vec;
  assign pipe_in_valid = iss_valid_q;
  assign pipe_in_data  = iss_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign quiesce_done  = (state_q == ST_QUIET);
  assign err_sticky    = err_sticky_q;

`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_vec[i] && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stat_cnt = cnt_q[stat_sel];
`endif

endmodule

// File: tb/tb_ptp_bridge_pipe_arb.sv
// Directed bench for ptp_bridge_pipe_arb with NREQ=4, W=32, DLY=2.
// A behavioural DLY-stage pipeline (not reset) closes the loop; inj_v/inj_d
// force a spurious result strobe.
module tb_ptp_bridge_pipe_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int DLY  = 2;
  localparam logic [31:0] BASE = 32'hC0DE_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              pipe_in_valid;
  logic [W-1:0]      pipe_in_data;
  logic              pipe_out_valid;
  logic [W-1:0]      pipe_out_data;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              quiesce;
  logic              quiesce_done;
  logic              err_sticky;
`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
  logic [1:0]        stat_sel;
  logic [15:0]       stat_cnt;
`endif

  logic [1:0]   pv_sh = '0;
  logic [W-1:0] pd_sh [2];
  logic         inj_v = 1'b0;
  logic [W-1:0] inj_d = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv_sh[0] <= pipe_in_valid;
    pv_sh[1] <= pv_sh[0];
    pd_sh[0] <= pipe_in_data;
    pd_sh[1] <= pd_sh[0];
  end

  assign pipe_out_valid = pv_sh[1] | inj_v;
  assign pipe_out_data  = inj_v ? inj_d : pd_sh[1];

  ptp_bridge_pipe_arb #(.NREQ(NREQ), .W(W), .DLY(DLY)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_data   (pipe_in_data),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_data  (pipe_out_data),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .quiesce        (quiesce),
    .quiesce_done   (quiesce_done),
    .err_sticky     (err_sticky)
`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
    ,
    .stat_sel       (stat_sel),
    .stat_cnt       (stat_cnt)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = BASE + 32'(i);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    quiesce   = 1'b0;
    set_default_data();
    #3;
    chk_cnt++; if (req_ready !== 4'h0) $display("FAIL reset_ready got=%h exp=0", req_ready); else pass_cnt++;
    chk_cnt++; if (pipe_in_valid !== 1'b0) $display("FAIL reset_pin got=%b exp=0", pipe_in_valid); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 4'h0) $display("FAIL reset_rsp got=%h exp=0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (quiesce_done !== 1'b0) $display("FAIL reset_qdone got=%b exp=0", quiesce_done); else pass_cnt++;
    chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_sticky); else pass_cnt++;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) next_cycle();
    chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL reset_err_idle got=%b exp=0", err_sticky); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy, exp_rsp;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      exp_rsp = (k >= 4) ? 4'(1 << ((k - 4) % 4)) : 4'h0;
      chk_cnt++; if (req_ready !== exp_rdy) $display("FAIL rr_ready k=%0d got=%h exp=%h", k, req_ready, exp_rdy); else pass_cnt++;
      chk_cnt++; if (pipe_in_valid !== (k >= 1 && k <= 8)) $display("FAIL rr_pin k=%0d got=%b", k, pipe_in_valid); else pass_cnt++;
      if (k >= 1 && k <= 8) begin
        chk_cnt++; if (pipe_in_data !== BASE + 32'((k - 1) % 4)) $display("FAIL rr_pdata k=%0d got=%h", k, pipe_in_data); else pass_cnt++;
      end
      chk_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL rr_rsp k=%0d got=%h exp=%h", k, rsp_valid, exp_rsp); else pass_cnt++;
      if (k >= 4) begin
        chk_cnt++; if (rsp_data !== BASE + 32'((k - 4) % 4)) $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, rsp_data, BASE + 32'((k - 4) % 4)); else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 2) ? 4'b0100 : 4'b0000;
      req_data[2*W +: W] = (k == 0) ? 32'hA5A5_0001 : 32'hA5A5_0002;
      @(negedge clk);
      chk_cnt++; if (req_ready !== ((k < 2) ? 4'b0100 : 4'b0000)) $display("FAIL b2b_ready k=%0d got=%h", k, req_ready); else pass_cnt++;
      chk_cnt++; if (pipe_in_valid !== (k == 1 || k == 2)) $display("FAIL b2b_pin k=%0d got=%b", k, pipe_in_valid); else pass_cnt++;
      if (k == 1 || k == 2) begin
        exp_d = (k == 1) ? 32'hA5A5_0001 : 32'hA5A5_0002;
        chk_cnt++; if (pipe_in_data !== exp_d) $display("FAIL b2b_pdata k=%0d got=%h exp=%h", k, pipe_in_data, exp_d); else pass_cnt++;
      end
      chk_cnt++; if (rsp_valid !== ((k == 4 || k == 5) ? 4'b0100 : 4'b0000)) $display("FAIL b2b_rsp k=%0d got=%h", k, rsp_valid); else pass_cnt++;
      if (k >= 4) begin
        exp_d = (k == 4) ? 32'hA5A5_0001 : 32'hA5A5_0002;
        chk_cnt++; if (rsp_data !== exp_d) $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rsp_data, exp_d); else pass_cnt++;
      end
      next_cycle();
    end
    set_default_data();
  endtask

  task automatic test_quiesce();
    logic [3:0] exp_rdy, exp_rsp;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k <= 8) ? 4'hF : 4'h0;
      quiesce   = (k >= 2 && k <= 6);
      @(negedge clk);
      exp_rdy = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : (k == 8) ? 4'b0010 : 4'b0000;
      exp_rsp = (k == 4) ? 4'b1000 : (k == 5) ? 4'b0001 : 4'b0000;
      chk_cnt++; if (req_ready !== exp_rdy) $display("FAIL q_ready k=%0d got=%h exp=%h", k, req_ready, exp_rdy); else pass_cnt++;
      chk_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL q_rsp k=%0d got=%h exp=%h", k, rsp_valid, exp_rsp); else pass_cnt++;
      if (k == 4 || k == 5) begin
        chk_cnt++; if (rsp_data !== ((k == 4) ? BASE + 32'd3 : BASE)) $display("FAIL q_rdata k=%0d got=%h", k, rsp_data); else pass_cnt++;
      end
      chk_cnt++; if (quiesce_done !== (k == 6 || k == 7)) $display("FAIL q_done k=%0d got=%b", k, quiesce_done); else pass_cnt++;
      next_cycle();
    end
    repeat (6) next_cycle();
  endtask

  task automatic test_err();
    @(negedge clk);
    chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL err_pre got=%b exp=0", err_sticky); else pass_cnt++;
    next_cycle();
    inj_v = 1'b1;
    inj_d = 32'hDEAD_BEEF;
    next_cycle();
    inj_v = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk_cnt++; if (err_sticky !== 1'b1) $display("FAIL err_set k=%0d got=%b exp=1", k, err_sticky); else pass_cnt++;
      chk_cnt++; if (rsp_valid !== 4'h0) $display("FAIL err_norsp k=%0d got=%h exp=0", k, rsp_valid); else pass_cnt++;
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL err_clr got=%b exp=0", err_sticky); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'hF;
      @(negedge clk);
      chk_cnt++; if (req_ready !== 4'(1 << k)) $display("FAIL rif_ready k=%0d got=%h exp=%h", k, req_ready, 4'(1 << k)); else pass_cnt++;
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (req_ready !== 4'h0) $display("FAIL rif_rst_ready got=%h exp=0", req_ready); else pass_cnt++;
    chk_cnt++; if (pipe_in_valid !== 1'b0) $display("FAIL rif_rst_pin got=%b exp=0", pipe_in_valid); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 4'h0) $display("FAIL rif_rst_rsp got=%h exp=0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (quiesce_done !== 1'b0) $display("FAIL rif_rst_qdone got=%b exp=0", quiesce_done); else pass_cnt++;
    chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL rif_rst_err got=%b exp=0", err_sticky); else pass_cnt++;
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    for (int k = 4; k <= 8; k++) begin
      req_valid = (k <= 5) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k <= 5) begin
        chk_cnt++; if (req_ready !== 4'(1 << (k - 4))) $display("FAIL rif_ready k=%0d got=%h exp=%h", k, req_ready, 4'(1 << (k - 4))); else pass_cnt++;
      end
      chk_cnt++; if (rsp_valid !== ((k == 8) ? 4'b0001 : 4'b0000)) $display("FAIL rif_rsp k=%0d got=%h", k, rsp_valid); else pass_cnt++;
      chk_cnt++; if (err_sticky !== 1'b0) $display("FAIL rif_err k=%0d got=%b exp=0", k, err_sticky); else pass_cnt++;
      if (k == 8) begin
        chk_cnt++; if (rsp_data !== BASE) $display("FAIL rif_rdata got=%h exp=%h", rsp_data, BASE); else pass_cnt++;
      end
      next_cycle();
    end
    repeat (4) next_cycle();
  endtask

`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) next_cycle();
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0010;
      next_cycle();
    end
    req_valid = 4'b0000;
    stat_sel  = 2'd1;
    @(negedge clk);
    chk_cnt++; if (stat_cnt !== 16'd5) $display("FAIL stat_r1 got=%0d exp=5", stat_cnt); else pass_cnt++;
    stat_sel = 2'd0;
    #1;
    chk_cnt++; if (stat_cnt !== 16'd0) $display("FAIL stat_r0 got=%0d exp=0", stat_cnt); else pass_cnt++;
    repeat (6) next_cycle();
  endtask
`endif

  initial begin
    req_data = '0;
`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
    stat_sel = '0;
`endif
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_quiesce();
    test_err();
    test_reset_inflight();
`ifdef PTP_BRIDGE_PIPE_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ptp_bridge_pipe_arb.md
PTP_BRIDGE_PIPE_ARB -- requirements
Module: ptp_bridge_pipe_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter W, default 32: payload width.
REQ-003 SHALL have parameter DLY, default 2: fixed latency of the shared pipeline, 1..16.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester request valid.
REQ-007 SHALL have port req_data  in  NREQ*W  per-requester payload; requester i at bits [i*W +: W].
REQ-008 SHALL have port req_ready  out  NREQ  one-hot-or-zero grant; a handshake is valid&ready on the same bit.
REQ-009 SHALL have port pipe_in_valid  out  1  issue strobe to the shared pipeline.
REQ-010 SHALL have port pipe_in_data  out  W  issued payload.
REQ-011 SHALL have port pipe_out_valid  in  1  pipeline result strobe.
REQ-012 SHALL have port pipe_out_data  in  W  pipeline result.
REQ-013 SHALL have port rsp_valid  out  NREQ  one-hot-or-zero result strobe to the owning requester.
REQ-014 SHALL have port rsp_data  out  W  result payload, shared by all requesters.
REQ-015 SHALL have port quiesce  in  1  level; stop granting and drain.
REQ-016 SHALL have port quiesce_done  out  1  high when quiesced and nothing is in flight.
REQ-017 SHALL have port err_sticky  out  1  tag/valid mismatch seen.

Function
REQ-018 SHALL arbitrate round-robin: the search starts at requester rr_ptr+1 mod NREQ, and rr_ptr updates to the granted index on each handshake.
REQ-019 SHALL drive req_ready combinationally from req_valid, rr_ptr and state, with at most one bit set.
REQ-020 SHALL register a handshake at cycle t and present it as pipe_in_valid=1 and pipe_in_data at cycle t+1; pipe_in_valid SHALL otherwise be 0.
REQ-021 SHALL track each issue in a DLY-deep shift register of {valid, index}, aligned so that entry DLY-1 corresponds to pipe_out_valid.
REQ-022 SHALL register a result: pipe_out_valid at cycle u SHALL produce rsp_valid[tracked index]=1 and rsp_data=pipe_out_data at cycle u+1.
REQ-023 SHALL therefore have an end-to-end latency from handshake to rsp_valid of exactly DLY+2 cycles.
REQ-024 SHALL sustain one grant per cycle, with no bubbles, while any requester is valid.
REQ-025 SHALL hold rsp_data at its last value when rsp_valid is 0.
REQ-026 SHALL set err_sticky when pipe_out_valid differs from the tracked valid bit; err_sticky SHALL clear only on reset.
REQ-027 On a mismatch with pipe_out_valid=1 and the tracked valid bit 0, SHALL drop the result, so that no rsp_valid is asserted.
REQ-028 SHALL implement the state machine RUN / DRAIN / QUIET.
REQ-029 RUN SHALL grant normally and SHALL go to DRAIN when quiesce=1; the grant is suppressed in that same cycle.
REQ-030 DRAIN SHALL grant nothing and SHALL go to QUIET when the tracker and the issue register are empty.
REQ-031 QUIET SHALL grant nothing and SHALL return to RUN when quiesce=0; granting resumes the cycle after the return.
REQ-032 SHALL return from DRAIN to RUN, keeping in-flight entries, if quiesce falls during DRAIN.
REQ-033 SHALL assert quiesce_done only in QUIET.
REQ-034 When quiesce rises in a cycle with a pending handshake, SHALL not complete that handshake.
REQ-035 SHALL leave rr_ptr unchanged in cycles with no handshake.

Reset
REQ-036 On rst_n low, SHALL asynchronously clear: req_ready, pipe_in_valid, rsp_valid, the tracker, err_sticky and quiesce_done to 0; state to RUN; rr_ptr to NREQ-1, so that requester 0 wins first.
REQ-037 SHALL discard in-flight results arriving after reset release without setting err_sticky only if they arrive within DLY cycles of release.

Configuration
REQ-038 With PTP_BRIDGE_PIPE_ARB_STATS_EN defined, SHALL add input stat_sel (clog2(NREQ) bits) and output stat_cnt (16 bits).
REQ-039 With PTP_BRIDGE_PIPE_ARB_STATS_EN defined, stat_cnt SHALL give the registered grant count of requester stat_sel, saturating at 0xFFFF and reset to 0.
REQ-040 Without PTP_BRIDGE_PIPE_ARB_STATS_EN, the stat_sel and stat_cnt ports and the counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-041 SHALL cover: NREQ=4, DLY=2, all req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rsp_valid exactly 4 cycles after its grant, with matching data.
REQ-042 SHALL cover: only requester 2 valid, with data 0xA5A5_0001 then 0xA5A5_0002 -> back-to-back pipe_in_valid; rsp_valid[2] on two consecutive cycles, in order.
REQ-043 SHALL cover: quiesce raised with 2 requests in flight -> no further req_ready; quiesce_done rises 1 cycle after the last rsp_valid; quiesce low -> grant on the next valid cycle.
REQ-044 SHALL cover: an injected pipe_out_valid with the tracker empty -> err_sticky=1, no rsp_valid; err_sticky held until rst_n low.
REQ-045 SHALL cover: rst_n asserted while 3 requests are in flight -> all outputs 0 immediately; the first grant after release goes to requester 0.
REQ-046 SHALL cover, with STATS_EN: 5 grants to requester 1 -> stat_sel=1 reads stat_cnt=5.
